mkio_tx_encoder: RTL and testbench
==================================

// Module: mkio_tx_encoder
// PURPOSE
//  MKIO (GOST R 52070) Manchester-II transmit encoder, directly downstream of the RT device FSMs.
//  Consumes the 16-bit word + sync-type strobe (tx_data/tx_cd/tx_ready); returns tx_busy.
//  Emits sync, 16 data bits MSB-first and odd parity as a bi-phase bit stream to the bus transceiver.
//  Has a one-word holding register so consecutive words go out back-to-back with no gap.
// PARAMETERS
//  HALF_BIT_CLKS     25    clk cycles per 0.5 us half-bit (50 MHz -> 1 Mbit/s); legal range 2..255
//  TIMEOUT_HALFBITS  1600  max continuous transmit length in half-bits (800 us); used only with MKIO_TX_TIMEOUT_EN
// PORTS
//  clk         in   1   system clock; single clock domain
//  reset       in   1   asynchronous, active-high reset
//  tx_data     in   16  word to transmit; sampled on the accepting cycle
//  tx_cd       in   1   sync type: 0 = command/status sync, 1 = data sync; sampled with tx_data
//  tx_ready    in   1   request strobe; only its rising edge is significant (may be held several clks)
//  tx_busy     out  1   high while a word is shifting or the holding register is occupied
//  tx_full     out  1   holding register occupied
//  tx_overrun  out  1   one-clk pulse: request dropped because holding register was full
//  line_p      out  1   positive bus drive
//  line_n      out  1   negative bus drive; equals ~line_p while tx_en = 1
//  tx_en       out  1   transceiver enable (inhibit when 0)
//  tx_timeout  out  1   fail-safe tripped (sticky); constant 0 without MKIO_TX_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async): every output 0; shifter, holding register, counters and tx_ready edge detector cleared.
//  Request edge: tx_ready = 1 in a cycle where it was 0 in the previous cycle.
//  Accept:
//   - shifter idle: word loads straight into the shifter.
//     Next cycle: tx_busy = 1, tx_en = 1, first sync half-bit on line_p.
//   - shifter active and holding empty: word goes into holding; tx_full = 1 next cycle.
//   - holding full: word dropped; tx_overrun = 1 for exactly one cycle.
//  Word frame = 40 half-bits, each HALF_BIT_CLKS clks, so one word = 40*HALF_BIT_CLKS clks (20 us):
//   - SYNC (6 half-bits): cd=0 -> line_p 1,1,1,0,0,0; cd=1 -> 0,0,0,1,1,1
//   - DATA (32 half-bits): tx_data[15] first; bit 1 -> 1,0; bit 0 -> 0,1
//   - PARITY (2 half-bits): P = ~^tx_data, so total ones including P is odd; encoded like a data bit
//  FSM: IDLE -> SYNC -> DATA -> PARITY. At the end of PARITY:
//   - holding full: load holding into shifter, go to SYNC on the next cycle (no dead time); tx_full -> 0
//   - holding empty: go to IDLE; line_p = line_n = tx_en = tx_busy = 0 on the following cycle
//  Simultaneous events:
//   - request edge in the last cycle of PARITY with holding empty: word loads straight into the shifter, no gap
//   - request edge in the same cycle holding drains: the new word is accepted into holding
//  Half-bit prescaler restarts at 0 on every load from IDLE. Line level changes only on half-bit boundaries.
//  Reset mid-word: outputs drop to 0 immediately; the next request edge starts a clean frame.
// CONFIGURATION
//  MKIO_TX_TIMEOUT_EN defined:
//   - counts half-bits of continuous tx_en = 1 time; the counter clears whenever tx_en = 0
//   - when the count reaches TIMEOUT_HALFBITS: abort frame, clear holding, drive line_p/line_n/tx_en/tx_busy to 0
//   - tx_timeout = 1 sticky until reset; while it is set, request edges are ignored (no overrun pulse)
//  MKIO_TX_TIMEOUT_EN undefined: no counter is built; tx_timeout tied 0; transmission length is unbounded.
// STRUCTURE
//  mkio_pkg holds:
//   - state enum (IDLE/SYNC/DATA/PARITY)
//   - SYNC_CMD = 6'b111000, SYNC_DATA = 6'b000111
//   - HALFBITS_SYNC = 6, HALFBITS_WORD = 40
//  Sub-module mkio_halfbit_timer: prescaler with sync clear, one-clk half-bit strobe every HALF_BIT_CLKS.
//  Top holds the edge detector, holding register, 40-half-bit pattern shifter, FSM and optional timeout.
// TESTING (sim with HALF_BIT_CLKS = 4)
//  1. tx_data = 16'h0800, tx_cd = 0, tx_ready held 3 clks -> sync 111000, data pattern for 0x0800, P = 0;
//     tx_busy high for exactly 160 clks; line idle after.
//  2. tx_data = 16'hFFFF, tx_cd = 1 -> sync 000111, sixteen "10" pairs, P = 1 ("10"); tx_en = 1 for 160 clks.
//  3. Second request edge (16'h1234, cd = 1) 40 clks into word 1 -> tx_full = 1;
//     word 2 sync starts the cycle after word 1 parity; tx_busy high continuously for 320 clks.
//  4. Third request edge while tx_full = 1 -> tx_overrun = 1 for 1 clk; only two words appear on the line.
//  5. Assert reset at half-bit 20 of a word -> line_p/line_n/tx_en/tx_busy = 0 same cycle;
//     after release, 16'h0001 cd = 0 transmits correctly with P = 0.
//  6. MKIO_TX_TIMEOUT_EN, TIMEOUT_HALFBITS = 100, continuous feed -> abort at half-bit 100 (400 clks);
//     tx_timeout = 1 sticky; later requests ignored.

Source files
------------

// File: rtl/mkio_tx_encoder_pkg.sv
// ---------------------------------------------------------------------------
// mkio_pkg
//   Shared definitions for the MKIO (GOST R 52070) Manchester-II transmit
//   encoder. It holds the FSM state encoding, the sync patterns, the frame
//   lengths in half-bits and a helper that expands one word into its
//   40-half-bit line pattern.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package mkio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  // Line levels of the six sync half-bits, first half-bit in the MSB.
  localparam logic [5:0] SYNC_CMD  = 6'b111000;
  localparam logic [5:0] SYNC_DATA = 6'b000111;

  localparam logic [5:0] HALFBITS_SYNC = 6'd6;
  localparam logic [5:0] HALFBITS_WORD = 6'd40;

  // Expands a word into line_p levels for the whole frame. The first
  // half-bit ends up in bit 39. The parity bit makes the total count of ones
  // odd, and it is encoded like a data bit.
  function automatic logic [39:0] build_frame(input logic [15:0] data,
                                              input logic        cd);
    logic [39:0] f;
    logic        p;
    f = {34'd0, (cd ? SYNC_DATA : SYNC_CMD)};
    for (int i = 15; i >= 0; i--) begin
      f = {f[37:0], (data[i] ? 2'b10 : 2'b01)};
    end
    p = ~^data;
    f = {f[37:0], (p ? 2'b10 : 2'b01)};
    return f;
  endfunction

endpackage

// File: rtl/mkio_tx_encoder_if.sv
// ---------------------------------------------------------------------------
// mkio_tx_encoder_if
//   Request/status bundle between the RT device FSMs (master) and the MKIO
//   transmit encoder (slave).
//   Signals:
//     tx_data[15:0]  word to transmit
//     tx_cd          sync type (0 = command/status, 1 = data)
//     tx_ready       request strobe
//     tx_busy        encoder shifting or holding register occupied
//     tx_full        holding register occupied
//     tx_overrun     one-clk pulse when a request was dropped
//
//   Handshake: only the rising edge of tx_ready counts, and it may be held
//   for several clocks. tx_data/tx_cd are sampled in the clock where
//   tx_ready is first seen high. There is no back-pressure. A request that
//   arrives while the holding register is full is dropped and reported on
//   tx_overrun, so the master should consult tx_full before raising
//   tx_ready.
// ---------------------------------------------------------------------------
interface mkio_tx_encoder_if;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_full;
  logic        tx_overrun;

  modport master (
    output tx_data, tx_cd, tx_ready,
    input  tx_busy, tx_full, tx_overrun
  );

  modport slave (
    input  tx_data, tx_cd, tx_ready,
    output tx_busy, tx_full, tx_overrun
  );
endinterface

// File: rtl/mkio_tx_encoder_halfbit_timer.sv
// ---------------------------------------------------------------------------
// mkio_halfbit_timer
//   Half-bit prescaler. While en is high it counts clk cycles and raises
//   strobe for one clock every HALF_BIT_CLKS cycles. clear restarts the
//   count at 0 synchronously.
//   Ports:
//     clk, reset   clock and asynchronous active-high reset
//     clear        synchronous restart of the prescaler
//     en           count enable
//     strobe       one-clk pulse in the last clock of each half-bit
// ---------------------------------------------------------------------------
module mkio_halfbit_timer #(
  parameter int HALF_BIT_CLKS = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic strobe
);

  localparam logic [7:0] LAST = 8'(HALF_BIT_CLKS - 1);

  logic [7:0] count_q;

  assign strobe = en & (count_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == LAST) ? 8'd0 : count_q + 8'd1;
    end
  end

endmodule

// File: rtl/mkio_tx_encoder.sv
// ---------------------------------------------------------------------------
// mkio_tx_encoder
//   MKIO (GOST R 52070) Manchester-II transmit encoder. Each accepted word
//   goes out as a 40-half-bit frame: sync (6), data MSB-first (32) and odd
//   parity (2). A one-word holding register lets consecutive words go out
//   back-to-back with no gap.
//   Parameters:
//     HALF_BIT_CLKS     clk cycles per half-bit (2..255)
//     TIMEOUT_HALFBITS  fail-safe limit in half-bits of continuous tx_en
//   Optional feature: define MKIO_TX_TIMEOUT_EN to build the fail-safe
//   timeout. Without it, tx_timeout is tied 0.
//   Ports:
//     clk, reset      clock and asynchronous active-high reset
//     tx              request/status bundle (slave side)
//     line_p, line_n  bi-phase drive to the bus transceiver
//     tx_en           transceiver enable
//     tx_timeout      sticky fail-safe flag
//     dbg_state       current FSM state, for observation only
// ---------------------------------------------------------------------------
module mkio_tx_encoder
  import mkio_pkg::*;
#(
  parameter int HALF_BIT_CLKS    = 25,
  parameter int TIMEOUT_HALFBITS = 1600
) (
  input  logic           clk,
  input  logic           reset,
  mkio_tx_encoder_if.slave tx,
  output logic           line_p,
  output logic           line_n,
  output logic           tx_en,
  output logic           tx_timeout,
  output state_t         dbg_state
);

  if (HALF_BIT_CLKS < 2 || HALF_BIT_CLKS > 255 || TIMEOUT_HALFBITS < 1) begin : g_param_check
    $error("mkio_tx_encoder: parameter out of range");
  end

  state_t      state_q, state_d;
  logic        ready_q;
  logic        req_edge, active, hb_stb, word_end, abort;
  logic        load_new, load_hold, shift_adv, hold_wr, timer_clr, overrun_d;
  logic        full_q, overrun_q, timeout_q;
  logic [15:0] hold_data_q;
  logic        hold_cd_q;
  logic [39:0] shift_q;
  logic [5:0]  hb_cnt_q;

  assign active   = (state_q != IDLE);
  // Once the fail-safe has tripped, requests are ignored entirely.
  assign req_edge = tx.tx_ready & ~ready_q & ~timeout_q;
  // This is the last clock of the final parity half-bit.
  assign word_end = active & hb_stb & (hb_cnt_q == HALFBITS_WORD - 6'd1);
  assign shift_adv = active & hb_stb & ~word_end & ~abort;

  mkio_halfbit_timer #(.HALF_BIT_CLKS(HALF_BIT_CLKS)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr),
    .en     (active),
    .strobe (hb_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_new  = 1'b0;
    load_hold = 1'b0;
    hold_wr   = 1'b0;
    timer_clr = 1'b0;
    overrun_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_edge) begin
            load_new  = 1'b1;
            timer_clr = 1'b1;
            state_d   = SYNC;
          end
        end
        default: begin
          if (hb_stb) begin
            if (hb_cnt_q == HALFBITS_SYNC - 6'd1) state_d = DATA;
            if (hb_cnt_q == HALFBITS_WORD - 6'd3) state_d = PARITY;
          end
          if (word_end) begin
            // The prescaler wraps by itself, so the next frame follows
            // with no dead time.
            if (full_q) begin
              load_hold = 1'b1;
              state_d   = SYNC;
            end else if (req_edge) begin
              load_new = 1'b1;
              state_d  = SYNC;
            end else begin
              state_d = IDLE;
            end
          end
          // A request is parked in holding unless it went straight into
          // the shifter above. Holding frees up in the same clock it drains.
          if (req_edge && !(word_end && !full_q)) begin
            if (!full_q || word_end) hold_wr   = 1'b1;
            else                     overrun_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      shift_q     <= '0;
      hb_cnt_q    <= '0;
      hold_data_q <= '0;
      hold_cd_q   <= 1'b0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ready_q   <= tx.tx_ready;
      overrun_q <= overrun_d;
      if (abort) begin
        shift_q  <= '0;
        hb_cnt_q <= '0;
      end else if (load_new) begin
        shift_q  <= build_frame(tx.tx_data, tx.tx_cd);
        hb_cnt_q <= '0;
      end else if (load_hold) begin
        shift_q  <= build_frame(hold_data_q, hold_cd_q);
        hb_cnt_q <= '0;
      end else if (shift_adv) begin
        shift_q  <= {shift_q[38:0], 1'b0};
        hb_cnt_q <= hb_cnt_q + 6'd1;
      end
      if (hold_wr) begin
        hold_data_q <= tx.tx_data;
        hold_cd_q   <= tx.tx_cd;
      end
      if (hold_wr)                full_q <= 1'b1;
      else if (load_hold || abort) full_q <= 1'b0;
    end
  end

`ifdef MKIO_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_HALFBITS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_HALFBITS - 1);

  logic [TO_W-1:0] to_cnt_q;

  // The count spans back-to-back frames and restarts only when tx_en drops.
  assign abort = active & hb_stb & (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!active)     to_cnt_q <= '0;
      else if (hb_stb) to_cnt_q <= to_cnt_q + 1'b1;
      if (abort) timeout_q <= 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign timeout_q = 1'b0;
`endif

  assign tx_en         = active;
  assign line_p        = active & shift_q[39];
  assign line_n        = active & ~shift_q[39];
  assign tx.tx_busy    = active | full_q;
  assign tx.tx_full    = full_q;
  assign tx.tx_overrun = overrun_q;
  assign tx_timeout    = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mkio_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_mkio_tx_encoder
//   Directed bench for mkio_tx_encoder with HALF_BIT_CLKS = 4. A word-level
//   model (current frame, pending-word queue, start cycle) predicts every
//   output on every clock. Hand-computed frame patterns and durations pin
//   the model itself.
// ---------------------------------------------------------------------------
module tb_mkio_tx_encoder;
  localparam int H     = 4;
  localparam int TO_HB = 100;

  logic clk = 1'b0;
  logic reset;
  logic line_p, line_n, tx_en, tx_timeout;
  mkio_pkg::state_t dbg_state;

  mkio_tx_encoder_if tx_bus();

  mkio_tx_encoder #(.HALF_BIT_CLKS(H), .TIMEOUT_HALFBITS(TO_HB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (tx_bus),
    .line_p     (line_p),
    .line_n     (line_n),
    .tx_en      (tx_en),
    .tx_timeout (tx_timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- word-level model ----------------
  // Line level of half-bit j of a frame for word w = {cd, data}.
  function automatic logic exp_level(input logic [16:0] w, input int j);
    logic [15:0] d;
    logic        b;
    d = w[15:0];
    if (j < 6) return w[16] ? (j >= 3) : (j < 3);
    if (j < 38) begin
      b = d[15 - (j - 6) / 2];
      return ((j - 6) % 2 == 0) ? b : ~b;
    end
    b = ($countones(d) % 2 == 0);
    return (j == 38) ? b : ~b;
  endfunction

  function automatic logic [39:0] model_frame(input logic [16:0] w);
    logic [39:0] f;
    for (int j = 0; j < 40; j++) f[39 - j] = exp_level(w, j);
    return f;
  endfunction

  logic [16:0] exp_q[$];
  logic [16:0] cur;
  bit          act = 1'b0;
  bit          ovr = 1'b0;
  bit          tmo = 1'b0;
  bit          prev_ready = 1'b0;
  int          cyc = 0;
  int          a = 0;
`ifdef MKIO_TX_TIMEOUT_EN
  int          en_start = 0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act = 1'b0;
      exp_q.delete();
      prev_ready = 1'b0;
      ovr = 1'b0;
      tmo = 1'b0;
    end else begin : step
      bit edge_seen;
      bit was_act;
      cyc++;
      ovr = 1'b0;
      edge_seen = tx_bus.tx_ready && !prev_ready;
      prev_ready = tx_bus.tx_ready;
`ifdef MKIO_TX_TIMEOUT_EN
      if (act && cyc == en_start + TO_HB * H) begin
        act = 1'b0;
        exp_q.delete();
        tmo = 1'b1;
      end
`endif
      was_act = act;
      if (act && cyc == a + 40 * H) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          a = cyc;
        end else begin
          act = 1'b0;
        end
      end
      if (edge_seen && !tmo) begin
        if (!act) begin
          act = 1'b1;
          cur = {tx_bus.tx_cd, tx_bus.tx_data};
          a = cyc;
`ifdef MKIO_TX_TIMEOUT_EN
          if (!was_act) en_start = cyc;
`endif
        end else if (exp_q.size() == 0) begin
          exp_q.push_back({tx_bus.tx_cd, tx_bus.tx_data});
        end else begin
          ovr = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic e_p;
    e_p = act ? exp_level(cur, (cyc - a) / H) : 1'b0;
    check("line_p", line_p, e_p);
    check("line_n", line_n, act ? !e_p : 1'b0);
    check("tx_en", tx_en, act);
    check("tx_busy", tx_bus.tx_busy, act || exp_q.size() > 0);
    check("tx_full", tx_bus.tx_full, exp_q.size() > 0);
    check("tx_overrun", tx_bus.tx_overrun, ovr);
    check("tx_timeout", tx_timeout, tmo);
    check("state_idle", dbg_state == mkio_pkg::IDLE, !act);
  end

  // ---------------- run-length monitors ----------------
  int busy_runs[$];
  int en_runs[$];
  int busy_len = 0;
  int en_len = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (tx_bus.tx_busy) busy_len++;
    else if (busy_len > 0) begin busy_runs.push_back(busy_len); busy_len = 0; end
    if (tx_en) en_len++;
    else if (en_len > 0) begin en_runs.push_back(en_len); en_len = 0; end
    if (tx_bus.tx_overrun) ovr_cnt++;
  end

  task automatic clear_mon();
    busy_runs.delete();
    en_runs.delete();
    ovr_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] d, input logic cd, input int hold);
    @(posedge clk);
    #1;
    tx_bus.tx_data  = d;
    tx_bus.tx_cd    = cd;
    tx_bus.tx_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    tx_bus.tx_ready = 1'b0;
  endtask

  task automatic wait_en(input int limit);
    int k;
    k = 0;
    while (tx_en !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("tx_en_start_within_limit", (k < limit), 1'b1);
  endtask

  // Called on the first negedge of a frame; samples mid half-bit and returns
  // on the negedge where the following frame would begin.
  task automatic grab(output logic [39:0] f);
    f = '0;
    for (int c = 0; c < 40 * H; c++) begin
      if (c % H == 1) f[39 - c / H] = line_p;
      @(negedge clk);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [39:0] f1, f2;
    reset = 1'b1;
    tx_bus.tx_data  = '0;
    tx_bus.tx_cd    = 1'b0;
    tx_bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {line_p, line_n, tx_en, tx_timeout, tx_bus.tx_busy,
                          tx_bus.tx_full, tx_bus.tx_overrun}, 7'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: single command-sync word, tx_ready held 3 clocks
    clear_mon();
    fork
      send(16'h0800, 1'b0, 3);
      begin wait_en(50); grab(f1); end
    join
    repeat (6) @(negedge clk);
    check("t1_frame", f1, {6'b111000, 8'h55, 8'h95, 16'h5555, 2'b01});
    check("t1_busy_clks", (busy_runs.size() > 0) ? busy_runs[0] : 0, 160);
    check("t1_idle_after", {line_p, line_n, tx_en, tx_bus.tx_busy}, 4'b0);

    // 2: data-sync word of all ones
    clear_mon();
    fork
      send(16'hFFFF, 1'b1, 1);
      begin wait_en(50); grab(f1); end
    join
    repeat (6) @(negedge clk);
    check("t2_frame", f1, {6'b000111, {16{2'b10}}, 2'b10});
    check("t2_en_clks", (en_runs.size() > 0) ? en_runs[0] : 0, 160);

    // 3+4: second word into holding, third word overruns
    clear_mon();
    fork
      send(16'hA5C3, 1'b0, 2);
      begin
        repeat (40) @(posedge clk);
        send(16'h1234, 1'b1, 2);
        @(negedge clk);
        check("t3_full_set", tx_bus.tx_full, 1'b1);
        repeat (30) @(posedge clk);
        send(16'hBEEF, 1'b0, 1);
      end
      begin wait_en(50); grab(f1); grab(f2); end
    join
    repeat (6) @(negedge clk);
    check("t3_frame1", f1, model_frame({1'b0, 16'hA5C3}));
    check("t3_frame2", f2, {6'b000111, 8'h56, 8'h59, 8'h5A, 8'h65, 2'b01});
    check("t3_busy_clks", (busy_runs.size() > 0) ? busy_runs[0] : 0, 320);
    check("t3_busy_runs", busy_runs.size(), 1);
    check("t4_overrun_pulses", ovr_cnt, 1);

    // 3b: request in the last parity clock with holding empty
    clear_mon();
    fork
      send(16'h0F0F, 1'b1, 1);
      begin
        wait_en(50);
        repeat (158) @(posedge clk);
        send(16'hF0F0, 1'b0, 1);
      end
    join
    repeat (180) @(negedge clk);
    check("t3b_en_clks", (en_runs.size() > 0) ? en_runs[0] : 0, 320);
    check("t3b_full_never", (busy_runs.size() > 0) ? busy_runs[0] : 0, 320);

    // 3c: request in the same clock holding drains
    clear_mon();
    fork
      send(16'h3C3C, 1'b0, 1);
      begin
        wait_en(50);
        repeat (20) @(posedge clk);
        send(16'hC3C3, 1'b1, 1);
        repeat (136) @(posedge clk);
        send(16'h8001, 1'b0, 1);
      end
    join
    repeat (340) @(negedge clk);
    check("t3c_busy_clks", (busy_runs.size() > 0) ? busy_runs[0] : 0, 480);
    check("t3c_no_overrun", ovr_cnt, 0);

    // 5: reset at half-bit 20, then a clean word
    fork
      send(16'h7E81, 1'b0, 1);
      begin wait_en(50); repeat (20 * H) @(negedge clk); end
    join
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("t5_reset_drop", {line_p, line_n, tx_en, tx_bus.tx_busy}, 4'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    fork
      send(16'h0001, 1'b0, 2);
      begin wait_en(50); grab(f1); end
    join
    repeat (6) @(negedge clk);
    check("t5_frame", f1, {6'b111000, {15{2'b01}}, 2'b10, 2'b01});
    check("t5_busy_clks", (busy_runs.size() > 0) ? busy_runs[0] : 0, 160);

`ifdef MKIO_TX_TIMEOUT_EN
    // 6: continuous feed trips the fail-safe after TO_HB half-bits
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      send(16'(16'h1000 + i), i[0], 1);
      repeat (100) @(posedge clk);
    end
    repeat (20) @(negedge clk);
    check("t6_en_clks", (en_runs.size() > 0) ? en_runs[0] : 0, TO_HB * H);
    check("t6_timeout", tx_timeout, 1'b1);
    send(16'h5A5A, 1'b1, 1);
    repeat (10) @(negedge clk);
    check("t6_ignored", {tx_en, tx_bus.tx_busy}, 2'b0);
    check("t6_timeout_sticky", tx_timeout, 1'b1);
    check("t6_overrun_pulses", ovr_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
